hdu_sb: RTL
===========

HDU_SB -- requirements
Module: hdu_sb

Interface
- REQ-001: Parameter REG_AW, default 4, register-address width; the scoreboard tracks 2**REG_AW registers.
- REQ-002: Parameter CNT_W, default 3, width of the memory-beat count.
- REQ-003: clk_i  in  1  sole clock; all state is on the rising edge.
- REQ-004: rst_i  in  1  asynchronous, active-low reset.
- REQ-005: dec_valid_i  in  1  decode holds a valid instruction.
- REQ-006: dec_rs1_i, dec_rs2_i  in  REG_AW each  decode source registers.
- REQ-007: dec_rs_use_i  in  2  bit0 = rs1 read, bit1 = rs2 read.
- REQ-008: dec_rd_i  in  REG_AW  decode destination; dec_rd_we_i  in  1  destination written.
- REQ-009: dec_is_load_i  in  1  decode instruction is a long-latency load.
- REQ-010: wb_valid_i  in  1, wb_rd_i  in  REG_AW  load result retired to wb_rd_i.
- REQ-011: x_mem_req_i  in  1, x_mem_beats_i  in  CNT_W  execute starts a memory access of x_mem_beats_i beats.
- REQ-012: x_branch_taken_i  in  1  execute redirects the PC.
- REQ-013: cu_stall_si_i  in  1  control unit self-instruct request.
- REQ-014: stall_fetch_o  out  1  hold fetch.
- REQ-015: stall_decode_o  out  1  hold decode.
- REQ-016: flush_decode_o  out  1  kill the decode instruction.
- REQ-017: busy_o  out  1  at least one load is pending.

Function
- REQ-018: The scoreboard is a 2**REG_AW-bit vector pend_q; bit 0 is always 0.
- REQ-019: Issue = dec_valid_i & ~stall_decode_o & ~flush_decode_o.
- REQ-020: On issue with dec_is_load_i & dec_rd_we_i & dec_rd_i != 0, pend_q[dec_rd_i] sets on the next edge.
- REQ-021: wb_valid_i clears pend_q[wb_rd_i] on the next edge; a simultaneous set and clear of the same bit leaves it set.
- REQ-022: raw = dec_valid_i & ((use[0] & pend[rs1]) | (use[1] & pend[rs2])).
- REQ-023: waw = dec_valid_i & dec_rd_we_i & pend[rd].
- REQ-024: FSM states are RUN, MEM_WAIT and FLUSH; the reset state is RUN.
- REQ-025: In RUN, x_mem_req_i with beats >= 2 loads cnt_q = beats-1 and enters MEM_WAIT; beats of 0 or 1 produce no stall.
- REQ-026: In MEM_WAIT, cnt_q decrements each cycle and the FSM returns to RUN on the edge where cnt_q == 1.
- REQ-027: In MEM_WAIT, x_mem_req_i and x_branch_taken_i are ignored.
- REQ-028: In RUN, x_branch_taken_i enters FLUSH for exactly one cycle and then returns to RUN.
- REQ-029: flush_decode_o = (state == RUN & x_branch_taken_i) | state == FLUSH.
- REQ-030: stall_decode_o = ~flush_decode_o & (state == MEM_WAIT | raw | waw).
- REQ-031: stall_fetch_o = cu_stall_si_i | stall_decode_o.
- REQ-032: busy_o = |pend_q.
- REQ-033: All outputs are combinational and depend on current inputs plus registered state only; there are no combinational loops.

Reset
- REQ-034: While rst_i = 0: pend_q = 0, cnt_q = 0, state = RUN, and all outputs are forced to 0.
- REQ-035: Reset asserted mid-MEM_WAIT or mid-FLUSH aborts immediately; the first cycle after release is RUN with no stall.

Configuration
- REQ-036: Macro HDU_WB_BYPASS_EN controls writeback bypass.
- REQ-037: With HDU_WB_BYPASS_EN defined, raw and waw use pend_q masked by the same-cycle wb_valid_i/wb_rd_i clear, so a dependency on the retiring register does not stall.
- REQ-038: Without HDU_WB_BYPASS_EN, raw and waw use registered pend_q only, which costs one extra stall cycle.

Structure
- REQ-039: Package hdu_pkg holds the state enum hdu_state_e (RUN, MEM_WAIT, FLUSH) and the default constants HDU_REG_AW = 4 and HDU_CNT_W = 3.
- REQ-040: Sub-module hdu_scoreboard holds pend_q, the set/clear logic and the raw/waw lookup.
- REQ-041: hdu_sb holds the FSM, beat counter and output logic.

Verification
- REQ-042: Load r5 issued, next instruction reads r5 via rs1, wb of r5 four cycles later -> stall_decode_o high until the wb cycle (bypass on) or wb+1 (bypass off); busy_o falls after wb.
- REQ-043: x_mem_req_i with beats = 4 in RUN -> stall_decode_o and stall_fetch_o high for exactly 3 cycles; beats = 1 -> no stall.
- REQ-044: x_branch_taken_i while raw is true -> flush_decode_o high for 2 cycles, stall_decode_o low in both.
- REQ-045: wb_valid_i for r7 coincides with issue of a new load to r7 -> pend_q[7] remains 1.
- REQ-046: rst_i pulled low for 1 cycle mid-MEM_WAIT (cnt_q = 2) -> all outputs 0, busy_o 0, no stall after release.
- REQ-047: cu_stall_si_i high with no hazard -> stall_fetch_o = 1, stall_decode_o = 0; a load to r0 never sets busy_o.

Source files
------------

// File: rtl/hdu_sb_pkg.sv
// ---------------------------------------------------------------------------
// hdu_pkg - shared types and defaults for the hazard-detection unit.
//   hdu_state_e : control FSM states (RUN, MEM_WAIT, FLUSH)
//   HDU_REG_AW  : default register-address width (16 registers)
//   HDU_CNT_W   : default width of the memory-beat count
// ---------------------------------------------------------------------------
package hdu_pkg;

  localparam int HDU_REG_AW = 4;
  localparam int HDU_CNT_W  = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } hdu_state_e;

endpackage

// File: rtl/hdu_sb_if.sv
// ---------------------------------------------------------------------------
// hdu_sb_if - pipeline-side signal bundle of the hazard-detection unit.
//   decode  : dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs_use_i, dec_rd_i,
//             dec_rd_we_i, dec_is_load_i
//   retire  : wb_valid_i, wb_rd_i
//   execute : x_mem_req_i, x_mem_beats_i, x_branch_taken_i
//   control : cu_stall_si_i
//   results : stall_fetch_o, stall_decode_o, flush_decode_o, busy_o
// Modport master is the pipeline side, slave is the hazard unit.
// ---------------------------------------------------------------------------
interface hdu_sb_if #(
  parameter int REG_AW = hdu_pkg::HDU_REG_AW,
  parameter int CNT_W  = hdu_pkg::HDU_CNT_W
) ();

  logic              dec_valid_i;
  logic [REG_AW-1:0] dec_rs1_i;
  logic [REG_AW-1:0] dec_rs2_i;
  logic [1:0]        dec_rs_use_i;
  logic [REG_AW-1:0] dec_rd_i;
  logic              dec_rd_we_i;
  logic              dec_is_load_i;
  logic              wb_valid_i;
  logic [REG_AW-1:0] wb_rd_i;
  logic              x_mem_req_i;
  logic [CNT_W-1:0]  x_mem_beats_i;
  logic              x_branch_taken_i;
  logic              cu_stall_si_i;
  logic              stall_fetch_o;
  logic              stall_decode_o;
  logic              flush_decode_o;
  logic              busy_o;

  modport master (
    output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs_use_i, dec_rd_i,
           dec_rd_we_i, dec_is_load_i, wb_valid_i, wb_rd_i, x_mem_req_i,
           x_mem_beats_i, x_branch_taken_i, cu_stall_si_i,
    input  stall_fetch_o, stall_decode_o, flush_decode_o, busy_o
  );

  modport slave (
    input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs_use_i, dec_rd_i,
           dec_rd_we_i, dec_is_load_i, wb_valid_i, wb_rd_i, x_mem_req_i,
           x_mem_beats_i, x_branch_taken_i, cu_stall_si_i,
    output stall_fetch_o, stall_decode_o, flush_decode_o, busy_o
  );

endinterface

// File: rtl/hdu_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// hdu_scoreboard - pending-load scoreboard with RAW/WAW lookup.
//   clk_i, rst_i   : clock, asynchronous active-low reset
//   set_en_i/rd_i  : a load to set_rd_i issues this cycle
//   wb_valid_i/rd_i: a load result retires to wb_rd_i this cycle
//   dec_*          : decode instruction operands for the hazard lookup
//   raw_o, waw_o   : dependency on a pending load
//   busy_o         : any load pending
// Optional feature: HDU_WB_BYPASS_EN lets the lookup see the same-cycle
// writeback clear so a retiring register no longer causes a stall.
// ---------------------------------------------------------------------------
module hdu_scoreboard #(
  parameter int REG_AW = hdu_pkg::HDU_REG_AW
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_en_i,
  input  logic [REG_AW-1:0] set_rd_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              dec_valid_i,
  input  logic [REG_AW-1:0] dec_rs1_i,
  input  logic [REG_AW-1:0] dec_rs2_i,
  input  logic [1:0]        dec_rs_use_i,
  input  logic [REG_AW-1:0] dec_rd_i,
  input  logic              dec_rd_we_i,
  output logic              raw_o,
  output logic              waw_o,
  output logic              busy_o
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0] pend_q, pend_d;
  logic [NREG-1:0] set_vec, clr_vec, pend_look;

  // Clear and set vectors are built separately: the set path depends on
  // issue, which depends on the lookup, which depends on the clear vector.
  always_comb begin
    clr_vec = '0;
    if (wb_valid_i) clr_vec[wb_rd_i] = 1'b1;
  end

  always_comb begin
    set_vec = '0;
    if (set_en_i) set_vec[set_rd_i] = 1'b1;
  end

  // Set wins over a same-cycle clear of the same register; r0 never pends.
  always_comb begin
    pend_d    = (pend_q & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) pend_q <= '0;
    else        pend_q <= pend_d;
  end

`ifdef HDU_WB_BYPASS_EN
  assign pend_look = pend_q & ~clr_vec;
`else
  assign pend_look = pend_q;
`endif

  assign raw_o  = dec_valid_i & ((dec_rs_use_i[0] & pend_look[dec_rs1_i]) |
                                 (dec_rs_use_i[1] & pend_look[dec_rs2_i]));
  assign waw_o  = dec_valid_i & dec_rd_we_i & pend_look[dec_rd_i];
  assign busy_o = |pend_q;

endmodule

// File: rtl/hdu_sb.sv
// ---------------------------------------------------------------------------
// hdu_sb - hazard-detection unit: pending-load scoreboard, multi-beat
// memory stall FSM and branch flush.
//   clk_i : clock          rst_i : asynchronous active-low reset
//   bus   : hdu_sb_if.slave (decode/retire/execute inputs, stall/flush/busy)
// Optional feature: HDU_WB_BYPASS_EN (writeback bypass in the scoreboard).
// ---------------------------------------------------------------------------
module hdu_sb
  import hdu_pkg::*;
#(
  parameter int REG_AW = HDU_REG_AW,
  parameter int CNT_W  = HDU_CNT_W
) (
  input logic     clk_i,
  input logic     rst_i,
  hdu_sb_if.slave bus
);

  hdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw, waw, pend_any;
  logic             flush, stall_dec, issue, set_en;

  assign issue  = bus.dec_valid_i & ~stall_dec & ~flush;
  assign set_en = issue & bus.dec_is_load_i & bus.dec_rd_we_i &
                  (bus.dec_rd_i != '0);

  hdu_scoreboard #(.REG_AW(REG_AW)) u_scoreboard (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .set_en_i     (set_en),
    .set_rd_i     (bus.dec_rd_i),
    .wb_valid_i   (bus.wb_valid_i),
    .wb_rd_i      (bus.wb_rd_i),
    .dec_valid_i  (bus.dec_valid_i),
    .dec_rs1_i    (bus.dec_rs1_i),
    .dec_rs2_i    (bus.dec_rs2_i),
    .dec_rs_use_i (bus.dec_rs_use_i),
    .dec_rd_i     (bus.dec_rd_i),
    .dec_rd_we_i  (bus.dec_rd_we_i),
    .raw_o        (raw),
    .waw_o        (waw),
    .busy_o       (pend_any)
  );

  // A branch in RUN takes precedence over a memory request in the same
  // cycle; MEM_WAIT ignores both and just counts its beats down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (bus.x_branch_taken_i) begin
          state_d = FLUSH;
        end else if (bus.x_mem_req_i && bus.x_mem_beats_i >= CNT_W'(2)) begin
          cnt_d   = bus.x_mem_beats_i - CNT_W'(1);
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RUN;
      end
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are gated by rst_i so they read 0 for the whole reset window,
  // even with branch or self-instruct requests present.
  assign flush     = rst_i & (((state_q == RUN) & bus.x_branch_taken_i) |
                              (state_q == FLUSH));
  assign stall_dec = rst_i & ~flush & ((state_q == MEM_WAIT) | raw | waw);

  assign bus.flush_decode_o = flush;
  assign bus.stall_decode_o = stall_dec;
  assign bus.stall_fetch_o  = rst_i & (bus.cu_stall_si_i | stall_dec);
  assign bus.busy_o         = rst_i & pend_any;

endmodule
